// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss timekeeping core with a validated time-set path.
// Counting is enabled by the one-cycle clk_1Hz strobe. Time-set requests
// pass through IDLE -> CHECK -> COMMIT; rejected requests pulse set_err.
// Optional 12 h display mapping: define TIME_KEEPER_12H_EN.
module time_keeper #(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       clk_1Hz,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       pm,
    output logic       day_tick,
    output logic       set_err
);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] hh_q, mm_q, ss_q;
    logic [7:0] hh_d, mm_d, ss_d;
    logic [7:0] sh_hh_q, sh_mm_q, sh_ss_q;
    logic       capture;
    logic       set_ready_q, set_err_q, set_err_d, day_tick_q, day_tick_d;
    logic       shadow_ok;
    logic       ss_wrap, mm_wrap, hh_wrap;

    // Two-digit BCD increment; caller handles the wrap back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both nibbles decimal and the value within its field limit.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    assign shadow_ok = bcd_ok(sh_hh_q, 8'h23) && bcd_ok(sh_mm_q, 8'h59) &&
                       bcd_ok(sh_ss_q, 8'h59);

    assign ss_wrap = (ss_q == 8'h59);
    assign mm_wrap = (mm_q == 8'h59);
    assign hh_wrap = (hh_q == 8'h23);

    // Set FSM: next state, shadow capture strobe and reject pulse.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        set_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (set_valid) begin
                    capture = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (shadow_ok) begin
                    state_d = COMMIT;
                end else begin
                    state_d   = IDLE;
                    set_err_d = 1'b1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Time next-state: a commit overrides (and swallows) a coincident strobe.
    always_comb begin
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        day_tick_d = 1'b0;
        if (state_q == COMMIT) begin
            hh_d = sh_hh_q;
            mm_d = sh_mm_q;
            ss_d = sh_ss_q;
        end else if (clk_1Hz) begin
            ss_d = ss_wrap ? 8'h00 : bcd_inc(ss_q);
            if (ss_wrap) begin
                mm_d = mm_wrap ? 8'h00 : bcd_inc(mm_q);
                if (mm_wrap) begin
                    hh_d       = hh_wrap ? 8'h00 : bcd_inc(hh_q);
                    day_tick_d = hh_wrap;
                end
            end
        end
    end

    // State, time, shadow and registered status outputs.
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state_q     <= IDLE;
            hh_q        <= RESET_HH;
            mm_q        <= RESET_MM;
            ss_q        <= RESET_SS;
            sh_hh_q     <= 8'h00;
            sh_mm_q     <= 8'h00;
            sh_ss_q     <= 8'h00;
            set_ready_q <= 1'b1;
            set_err_q   <= 1'b0;
            day_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            set_ready_q <= (state_d == IDLE);
            set_err_q   <= set_err_d;
            day_tick_q  <= day_tick_d;
            if (capture) begin
                sh_hh_q <= set_hh;
                sh_mm_q <= set_mm;
                sh_ss_q <= set_ss;
            end
        end
    end

    assign set_ready = set_ready_q;
    assign set_err   = set_err_q;
    assign day_tick  = day_tick_q;
    assign mm_bcd    = mm_q;
    assign ss_bcd    = ss_q;

`ifdef TIME_KEEPER_12H_EN
    logic [4:0] hbin, hdisp;

    // 24 h internal hour to 12 h display hour plus PM flag.
    always_comb begin
        hbin  = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);
        hdisp = hbin;
        pm    = 1'b0;
        if (hbin == 5'd0) begin
            hdisp = 5'd12;
        end else if (hbin == 5'd12) begin
            pm = 1'b1;
        end else if (hbin > 5'd12) begin
            hdisp = hbin - 5'd12;
            pm    = 1'b1;
        end
        if (hdisp >= 5'd10) hh_bcd = {4'h1, 4'(hdisp - 5'd10)};
        else                hh_bcd = {4'h0, hdisp[3:0]};
    end
`else
    assign hh_bcd = hh_q;
    assign pm     = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: table of set requests plus hand-written
// sequences for counting, midnight rollover and strobe/commit arbitration.
module tb_time_keeper;

    logic       clk_50Mhz = 1'b0;
    logic       rst = 1'b1;
    logic       clk_1Hz = 1'b0;
    logic       set_valid = 1'b0;
    logic       set_ready;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic [7:0] hh_bcd, mm_bcd, ss_bcd;
    logic       pm, day_tick, set_err;

    int nvec = 0;
    int nerr = 0;
    int cur_sec = 0;

    typedef struct {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    time_keeper dut (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .clk_1Hz(clk_1Hz),
        .set_valid(set_valid), .set_ready(set_ready),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
        .pm(pm), .day_tick(day_tick), .set_err(set_err)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int to_sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (int'(h[7:4]) * 10 + int'(h[3:0])) * 3600 +
               (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 +
               (int'(s[7:4]) * 10 + int'(s[3:0]));
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Expected {pm, displayed hour} for a 24 h hour value.
    function automatic logic [8:0] disp(input logic [7:0] h);
`ifdef TIME_KEEPER_12H_EN
        case (h)
            8'h00: return {1'b0, 8'h12};
            8'h12: return {1'b1, 8'h12};
            8'h13: return {1'b1, 8'h01};
            8'h14: return {1'b1, 8'h02};
            8'h15: return {1'b1, 8'h03};
            8'h16: return {1'b1, 8'h04};
            8'h17: return {1'b1, 8'h05};
            8'h18: return {1'b1, 8'h06};
            8'h19: return {1'b1, 8'h07};
            8'h20: return {1'b1, 8'h08};
            8'h21: return {1'b1, 8'h09};
            8'h22: return {1'b1, 8'h10};
            8'h23: return {1'b1, 8'h11};
            default: return {1'b0, h};
        endcase
`else
        return {1'b0, h};
`endif
    endfunction

    task automatic chk_time(input string name);
        logic [7:0] eh, em, es;
        eh = to_bcd(cur_sec / 3600);
        em = to_bcd((cur_sec / 60) % 60);
        es = to_bcd(cur_sec % 60);
        chk(name, {7'b0, pm, hh_bcd, mm_bcd, ss_bcd}, {7'b0, disp(eh), em, es});
    endtask

    task automatic strobe();
        clk_1Hz = 1'b1;
        step();
        clk_1Hz = 1'b0;
        cur_sec = (cur_sec + 1) % 86400;
    endtask

    // One set transaction. s_chk/s_com put a strobe in CHECK/COMMIT cycles;
    // hold keeps set_valid high (with other data) through CHECK and COMMIT.
    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic err, input logic s_chk, input logic s_com,
                          input logic hold);
        int n = 0;
        while (!set_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_before_set", 32'(set_ready), 32'd1);
        set_valid = 1'b1;
        set_hh = h; set_mm = m; set_ss = s;
        step();                                   // E0
        if (hold) begin
            set_hh = 8'h01; set_mm = 8'h02; set_ss = 8'h03;
        end else begin
            set_valid = 1'b0;
        end
        chk("ready_in_check", 32'(set_ready), 32'd0);
        clk_1Hz = s_chk;
        step();                                   // E1
        clk_1Hz = 1'b0;
        if (s_chk) cur_sec = (cur_sec + 1) % 86400;
        chk_time("time_after_e1");
        if (err) begin
            chk("reject_err_ready", {30'b0, set_err, set_ready}, 32'd3);
            step();
            chk("err_one_cycle", 32'(set_err), 32'd0);
            chk_time("time_after_reject");
        end else begin
            chk("accept_err_ready", {30'b0, set_err, set_ready}, 32'd0);
            clk_1Hz = s_com;
            step();                               // E2
            clk_1Hz = 1'b0;
            cur_sec = to_sec(h, m, s);
            chk_time("time_after_commit");
            chk("ready_tick_after_commit", {30'b0, set_ready, day_tick}, 32'd2);
        end
    endtask

    initial begin
        logic seen;
        vecs[0] = '{8'h23, 8'h59, 8'h58, 1'b0};
        vecs[1] = '{8'h12, 8'h3A, 8'h00, 1'b1};
        vecs[2] = '{8'h24, 8'h00, 8'h00, 1'b1};
        vecs[3] = '{8'h10, 8'h60, 8'h00, 1'b1};
        vecs[4] = '{8'h05, 8'h00, 8'h0F, 1'b1};
        vecs[5] = '{8'h19, 8'h45, 8'h07, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{8'h20, 8'h00, 8'h60, 1'b1};
        vecs[8] = '{8'h1A, 8'h00, 8'h00, 1'b1};

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        cur_sec = 0;
        chk_time("reset_time");
        chk("reset_flags", {29'b0, set_ready, day_tick, set_err}, 32'd4);

        // 61 strobes, 10 cycles apart
        seen = 1'b0;
        for (int i = 0; i < 61; i++) begin
            strobe();
            seen |= day_tick;
            for (int j = 0; j < 9; j++) begin
                step();
                seen |= day_tick;
            end
        end
        chk_time("count_61");
        chk("no_day_tick", 32'(seen), 32'd0);

        // Table of set requests
        for (int i = 0; i < 9; i++)
            do_set(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].err, 1'b0, 1'b0, 1'b0);

        // Midnight rollover
        do_set(8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe();
        chk_time("roll_235959");
        chk("roll_tick_before", 32'(day_tick), 32'd0);
        strobe();
        chk_time("roll_000000");
        chk("roll_tick", 32'(day_tick), 32'd1);
        step();
        chk("roll_tick_one_cycle", 32'(day_tick), 32'd0);

        // Strobe in the COMMIT cycle is discarded
        do_set(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_time("commit_no_inc");
        strobe();
        chk_time("after_commit_inc");

        // Strobe during CHECK advances old time; held request waits for ready
        do_set(8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_set(8'h07, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        step();                                   // held request accepted here
        set_valid = 1'b0;
        chk("held_accepted", 32'(set_ready), 32'd0);
        chk_time("held_not_yet");
        step(); step();
        cur_sec = to_sec(8'h01, 8'h02, 8'h03);
        chk_time("held_committed");

        // Reset while in CHECK discards the pending request
        set_valid = 1'b1;
        set_hh = 8'h12; set_mm = 8'h00; set_ss = 8'h00;
        step();
        set_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cur_sec = 0;
        chk("reset_mid_ready", 32'(set_ready), 32'd1);
        step(); step();
        chk_time("reset_mid_no_commit");

        // Hours across the 12 h mapping boundaries
        do_set(8'h13, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_set(8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_set(8'h11, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe();
        chk_time("noon_roll");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
